// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with BOOT / RUN / HALT control.
// Drives a combinational word-indexed instruction memory and registers the
// fetched word into the IF/ID pipeline register with 1-cycle latency.
// A redirect outranks stall and halt. Fetching an ECALL delivers it and then
// parks the stage in HALT until the next redirect.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target
// traps into HALT and sets a sticky 'misaligned' output. Without the macro the
// low two target bits are dropped before the PC is loaded.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h00000000,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] imem_instruction,
    output logic [31:0] imem_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        halted,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] ECALL     = 32'h00000073;
    localparam logic [7:0]  BOOT_LAST = 8'(BOOT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  boot_cnt_q, boot_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifinst_q, ifinst_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
    logic        target_mis;
`endif

    // Target as loaded into the PC; the low bits never reach the PC.
    always_comb begin
        target = {redirect_target[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
        target_mis = |redirect_target[1:0];
`endif
    end

    // Next-state and datapath: redirect > stall > halt/fetch.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        ifpc_d     = ifpc_q;
        ifinst_d   = ifinst_q;
        ifpc4_d    = ifpc4_q;
        count_d    = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d      = mis_q;
`endif
        pc_plus4   = pc_q + 32'd4;

        case (state_q)
            BOOT: begin
                // Redirects are ignored while booting; IF/ID stays empty.
                boot_cnt_d = boot_cnt_q + 8'd1;
                if (boot_cnt_q == BOOT_LAST) state_d = RUN;
            end
            RUN, HALT: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (target_mis) begin
                        state_d = HALT;
                        mis_d   = 1'b1;
                    end else begin
                        pc_d    = target;
                        state_d = RUN;
                    end
`else
                    pc_d    = target;
                    state_d = RUN;
`endif
                end else if (!stall) begin
                    if (state_q == HALT) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d  = 1'b1;
                        ifpc_d   = pc_q;
                        ifinst_d = imem_instruction;
                        ifpc4_d  = pc_plus4;
                        count_d  = count_q + 32'd1;
                        // ECALL is delivered but the PC stays on it.
                        if (imem_instruction == ECALL) state_d = HALT;
                        else                           pc_d    = pc_plus4;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State register with asynchronous reset back into a full BOOT delay.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q    <= BOOT;
            boot_cnt_q <= 8'd0;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            ifpc_q     <= 32'd0;
            ifinst_q   <= 32'd0;
            ifpc4_q    <= 32'd0;
            count_q    <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            ifpc_q     <= ifpc_d;
            ifinst_q   <= ifinst_d;
            ifpc4_q    <= ifpc4_d;
            count_q    <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q      <= mis_d;
`endif
        end
    end

    // Output mapping; the memory is addressed by word index.
    always_comb begin
        imem_pc           = {2'b00, pc_q[31:2]};
        if_id_valid       = valid_q;
        if_id_pc          = ifpc_q;
        if_id_instruction = ifinst_q;
        if_id_pc_plus4    = ifpc4_q;
        fetch_count       = count_q;
        halted            = (state_q == HALT);
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned        = mis_q;
`endif
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed literal scenarios followed by randomized
// stall / redirect / ECALL / reset traffic compared every cycle against a
// cycle-level reference of the fetch rules.
module tb_fetch_stage;

    localparam int BOOT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic [31:0] imem_pc;
    logic        v;
    logic [31:0] ipc, iinst, ipc4, cnt;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        mis;
`endif

    logic [31:0] mem [64];
    logic [31:0] instr;
    assign instr = mem[imem_pc[5:0]];

    fetch_stage #(.RESET_PC(32'h0), .BOOT_CYCLES(BOOT_CYCLES)) dut (
        .SYS_clk(clk), .SYS_reset(rst), .stall(stall),
        .redirect_valid(redir), .redirect_target(tgt),
        .imem_instruction(instr), .imem_pc(imem_pc),
        .if_id_valid(v), .if_id_pc(ipc), .if_id_instruction(iinst),
        .if_id_pc_plus4(ipc4), .halted(halted),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned(mis),
`endif
        .fetch_count(cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: mode 0 booting, 1 running, 2 halted.
    int          m_mode;
    int          m_boot;
    logic [31:0] m_pc, m_ipc, m_inst, m_ipc4, m_cnt;
    logic        m_v, m_mis;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_boot = 0; m_pc = 0; m_v = 0;
            m_ipc = 0; m_inst = 0; m_ipc4 = 0; m_cnt = 0; m_mis = 0;
        end else if (m_mode == 0) begin
            m_boot++;
            if (m_boot == BOOT_CYCLES) m_mode = 1;
        end else if (redir) begin
            m_v = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt % 4 != 0) begin m_mode = 2; m_mis = 1; end
            else begin m_pc = tgt; m_mode = 1; end
`else
            m_pc = tgt - (tgt % 4);
            m_mode = 1;
`endif
        end else if (!stall) begin
            if (m_mode == 2) m_v = 0;
            else begin
                m_v = 1; m_ipc = m_pc; m_inst = mem[(m_pc / 4) % 64];
                m_ipc4 = m_pc + 4; m_cnt = m_cnt + 1;
                if (m_inst == 32'h73) m_mode = 2;
                else m_pc = m_pc + 4;
            end
        end
    end

    bit chk_en = 1'b0;

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_pc", imem_pc, m_pc / 4);
            check("valid", {31'd0, v}, {31'd0, m_v});
            check("if_id_pc", ipc, m_ipc);
            check("if_id_instr", iinst, m_inst);
            check("if_id_pc4", ipc4, m_ipc4);
            check("fetch_count", cnt, m_cnt);
            check("halted", {31'd0, halted}, {31'd0, m_mode == 2});
`ifdef FETCH_MISALIGN_TRAP_EN
            check("misaligned", {31'd0, mis}, {31'd0, m_mis});
`endif
        end
    end

    // Advance one edge and land 2 time units after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h00500093;
        #2;
        // Reset state, no clock required.
        check("rst_valid", {31'd0, v}, 32'd0);
        check("rst_count", cnt, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_imem_pc", imem_pc, 32'd0);
        check("rst_if_id_pc", ipc, 32'd0);
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        // Boot delay of two cycles.
        tick(); check("boot0_valid", {31'd0, v}, 32'd0);
        tick(); check("boot1_valid", {31'd0, v}, 32'd0);
        tick(); check("f0_pc", ipc, 32'd0); check("f0_cnt", cnt, 32'd1);
        check("f0_valid", {31'd0, v}, 32'd1); check("f0_pc4", ipc4, 32'd4);
        tick(); check("f1_pc", ipc, 32'd4); check("f1_cnt", cnt, 32'd2);
        // Stall three cycles with pc at 8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_ifpc", ipc, 32'd4); check("stall_imem", imem_pc, 32'd2);
            check("stall_cnt", cnt, 32'd2);
        end
        stall = 1'b0;
        tick(); check("f2_pc", ipc, 32'd8); check("f2_cnt", cnt, 32'd3);
        // Redirect beats stall.
        stall = 1'b1; redir = 1'b1; tgt = 32'h40;
        tick(); check("rd_valid", {31'd0, v}, 32'd0); check("rd_imem", imem_pc, 32'd16);
        stall = 1'b0; redir = 1'b0;
        tick(); check("rd_ifpc", ipc, 32'h40); check("rd_valid2", {31'd0, v}, 32'd1);
        // ECALL at pc 12.
        mem[3] = 32'h00000073;
        redir = 1'b1; tgt = 32'd12;
        tick(); redir = 1'b0;
        check("ec_imem0", imem_pc, 32'd3);
        tick(); check("ec_ifpc", ipc, 32'd12); check("ec_inst", iinst, 32'h73);
        check("ec_halted", {31'd0, halted}, 32'd1); check("ec_imem1", imem_pc, 32'd3);
        tick(); check("ec_valid", {31'd0, v}, 32'd0); check("ec_imem2", imem_pc, 32'd3);
        check("ec_halted2", {31'd0, halted}, 32'd1);
        redir = 1'b1; tgt = 32'd0;
        tick(); redir = 1'b0; check("resume_halted", {31'd0, halted}, 32'd0);
        mem[3] = 32'h00500093;
        tick(); check("resume_ifpc", ipc, 32'd0); check("resume_valid", {31'd0, v}, 32'd1);
        // Misaligned redirect.
        redir = 1'b1; tgt = 32'h42;
        tick(); redir = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag", {31'd0, mis}, 32'd1); check("mis_halt", {31'd0, halted}, 32'd1);
        check("mis_imem", imem_pc, 32'd1);
        redir = 1'b1; tgt = 32'h40;
        tick(); redir = 1'b0;
`else
        check("mis_imem", imem_pc, 32'd16);
`endif
        tick(); check("mis_ifpc", ipc, 32'h40);
        // PC wrap at the top of the address space.
        redir = 1'b1; tgt = 32'hFFFFFFFC;
        tick(); redir = 1'b0;
        tick(); check("wrap_ifpc", ipc, 32'hFFFFFFFC); check("wrap_pc4", ipc4, 32'd0);
        check("wrap_imem", imem_pc, 32'd0);
        // Asynchronous reset in mid-cycle while valid.
        #1 rst = 1'b1;
        #1 check("arst_valid", {31'd0, v}, 32'd0); check("arst_cnt", cnt, 32'd0);
        check("arst_imem", imem_pc, 32'd0);
        tick(); rst = 1'b0;
        // Randomized traffic.
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 11) == 0) ? 32'h73 : $urandom;
        for (int n = 0; n < 3000; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: tgt = 32'hFFFFFFF0 + ($urandom_range(0, 15));
                1: tgt = $urandom;
                default: tgt = {24'd0, 6'($urandom), 2'b00};
            endcase
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
